// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  // Keeps vector widths legal when a count of 1 would give $clog2() == 0.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set request at or after ptr, wrapping at N-1 -> 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  always_comb begin : pick
    int  c;
    logic found;
    any   = |req;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = PW'(c);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ producers; write path is combinational.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arb_en,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DWIDTH-1:0]        fifo_din,
  output logic [$clog2(NREQ)-1:0]  fifo_src,
  output logic                     busy
);

  localparam int GW = clog2_min1(NREQ);
  localparam int CW = clog2_min1(MAX_BURST + 1);

  arb_state_t      state, state_nxt;
  logic [GW-1:0]   grant, grant_nxt;
  logic [GW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CW-1:0]   beat_cnt, beat_cnt_nxt;

  logic            pick_any;
  logic [GW-1:0]   pick_idx;
  logic            sel_valid;
  logic            sel_last;
  logic [DWIDTH-1:0] sel_data;
  logic            in_burst;
  logic            beat;

  rr_pick #(
    .N  (NREQ),
    .PW (GW)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Only the granted requester's lanes are ever looked at.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == GW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign in_burst = (state == ARB_BURST);
  assign beat     = in_burst & sel_valid & ~fifo_full;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    case (state)
      ARB_IDLE: begin
        if (arb_en && pick_any) begin
          grant_nxt    = pick_idx;
          beat_cnt_nxt = '0;
          state_nxt    = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (beat) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (sel_last || (beat_cnt == CW'(MAX_BURST - 1))) begin
            rr_ptr_nxt = (grant == GW'(NREQ - 1)) ? '0 : grant + 1'b1;
            state_nxt  = ARB_IDLE;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = in_burst & (grant == GW'(i)) & ~fifo_full;
    end
  end

  assign fifo_wr_en = beat;
  assign fifo_din   = beat ? sel_data : '0;
  assign fifo_src   = grant;
  assign busy       = in_burst;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: hand-computed beat/grant sequences plus a FIFO-occupancy stream.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int MB   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              arb_en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_din;
  logic [1:0]        fifo_src;
  logic              busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .arb_en     (arb_en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_src   (fifo_src),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int seq [NREQ];
  logic [DW-1:0] base [NREQ];
  logic [NREQ-1:0] fire;

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = base[i] + DW'(seq[i]);
  endtask

  // Records handshakes seen before the edge, then advances each producer past accepted beats.
  task automatic step();
    fire = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (fire[i]) seq[i]++;
    drive_data();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    arb_en    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      seq[i]  = 0;
      base[i] = '0;
    end
    drive_data();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    arb_en    = 1'b1;
    req_valid = '1;
    req_last  = '0;
    fifo_full = 1'b0;
    req_data  = '1;
    #12;
    checks++;
    if ({req_ready, fifo_wr_en, fifo_din, fifo_src, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b wr=%b din=%h src=%0d busy=%b exp all zero",
               req_ready, fifo_wr_en, fifo_din, fifo_src, busy);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic          exp_wr   [5] = '{0, 1, 1, 1, 0};
    logic [DW-1:0] exp_din  [5] = '{16'h0, 16'hA1, 16'hA2, 16'hA3, 16'h0};
    do_reset();
    base[0] = 16'hA1;
    drive_data();
    arb_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      req_valid = (c < 4) ? 4'b0001 : 4'b0000;
      req_last  = (c == 3) ? 4'b0001 : 4'b0000;
      if (c == 0) #1;
      else @(negedge clk);
      checks++;
      if (fifo_wr_en !== exp_wr[c] || busy !== exp_wr[c]) begin
        errors++;
        $display("FAIL single_wr c=%0d got wr=%b busy=%b exp %b", c, fifo_wr_en, busy, exp_wr[c]);
      end
      checks++;
      if (fifo_din !== exp_din[c] || fifo_src !== 2'd0) begin
        errors++;
        $display("FAIL single_data c=%0d got din=%h src=%0d exp din=%h src=0", c, fifo_din, fifo_src, exp_din[c]);
      end
    end
  endtask

  task automatic test_round_robin();
    int b, pos, src;
    logic          e_wr;
    logic [DW-1:0] e_din;
    do_reset();
    for (int i = 0; i < NREQ; i++) base[i] = DW'(i * 256);
    drive_data();
    arb_en    = 1'b1;
    req_valid = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) step();
      if (c == 0) #1;
      else @(negedge clk);
      b     = c / 5;
      pos   = c % 5;
      src   = b % 4;
      e_wr  = (pos != 0);
      e_din = e_wr ? DW'(src * 256 + (b / 4) * 4 + pos - 1) : '0;
      checks++;
      if (fifo_wr_en !== e_wr || busy !== e_wr) begin
        errors++;
        $display("FAIL rr_wr c=%0d got wr=%b busy=%b exp %b", c, fifo_wr_en, busy, e_wr);
      end
      if (e_wr) begin
        checks++;
        if (fifo_src !== 2'(src) || fifo_din !== e_din) begin
          errors++;
          $display("FAIL rr_data c=%0d got src=%0d din=%h exp src=%0d din=%h", c, fifo_src, fifo_din, src, e_din);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    logic          e_wr, e_busy;
    logic [DW-1:0] e_din;
    do_reset();
    base[2] = 16'h0020;
    drive_data();
    arb_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      req_valid = (seq[2] < 3) ? 4'b0100 : 4'b0000;
      req_last  = (seq[2] == 2) ? 4'b0100 : 4'b0000;
      fifo_full = (c >= 3 && c <= 5);
      if (c == 0) #1;
      else @(negedge clk);
      e_wr   = (c == 1 || c == 2 || c == 6);
      e_busy = (c >= 1 && c <= 6);
      e_din  = (c == 1) ? 16'h20 : (c == 2) ? 16'h21 : (c == 6) ? 16'h22 : 16'h0;
      checks++;
      if (fifo_wr_en !== e_wr || req_ready !== (e_wr ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL stall_wr c=%0d got wr=%b ready=%b exp wr=%b", c, fifo_wr_en, req_ready, e_wr);
      end
      checks++;
      if (fifo_din !== e_din || busy !== e_busy) begin
        errors++;
        $display("FAIL stall_data c=%0d got din=%h busy=%b exp din=%h busy=%b", c, fifo_din, busy, e_din, e_busy);
      end
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    base[0] = 16'h0000;
    base[1] = 16'h0010;
    drive_data();
    arb_en    = 1'b1;
    req_valid = 4'b0010;
    #1;
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_src !== 2'd1 || fifo_din !== 16'h0011) begin
      errors++;
      $display("FAIL arst_pre got wr=%b src=%0d din=%h exp wr=1 src=1 din=0011", fifo_wr_en, fifo_src, fifo_din);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, fifo_wr_en, fifo_din, fifo_src, busy} !== '0) begin
      errors++;
      $display("FAIL arst_zero got ready=%b wr=%b din=%h src=%0d busy=%b exp all zero",
               req_ready, fifo_wr_en, fifo_din, fifo_src, busy);
    end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b0011;
    #1;
    checks++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL arst_idle got busy=%b wr=%b exp 0 0", busy, fifo_wr_en);
    end
    step();
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_src !== 2'd0 || fifo_din !== 16'h0000) begin
      errors++;
      $display("FAIL arst_regrant got wr=%b src=%0d din=%h exp wr=1 src=0 din=0000", fifo_wr_en, fifo_src, fifo_din);
    end
  endtask

  task automatic test_arb_en();
    logic          e_wr;
    logic [1:0]    e_src;
    logic [DW-1:0] e_din;
    do_reset();
    base[0] = 16'h0000;
    base[3] = 16'h0030;
    drive_data();
    for (int c = 0; c < 11; c++) begin
      if (c > 0) step();
      arb_en    = (c < 2 || c >= 8);
      req_valid = (c < 2) ? 4'b1000 : 4'b1001;
      if (c == 0) #1;
      else @(negedge clk);
      e_wr  = (c >= 1 && c <= 4) || (c >= 9);
      e_src = (c >= 9) ? 2'd0 : 2'd3;
      e_din = (c >= 1 && c <= 4) ? DW'(16'h30 + c - 1) : (c >= 9) ? DW'(c - 9) : '0;
      checks++;
      if (fifo_wr_en !== e_wr || busy !== e_wr) begin
        errors++;
        $display("FAIL arben_wr c=%0d got wr=%b busy=%b exp %b", c, fifo_wr_en, busy, e_wr);
      end
      if (e_wr) begin
        checks++;
        if (fifo_src !== e_src || fifo_din !== e_din) begin
          errors++;
          $display("FAIL arben_data c=%0d got src=%0d din=%h exp src=%0d din=%h", c, fifo_src, fifo_din, e_src, e_din);
        end
      end
    end
  endtask

  task automatic test_fifo_stream();
    int  cnt;
    int  exp_seq [NREQ];
    bit  rd, done;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      base[i]    = DW'(i * 256);
      exp_seq[i] = 0;
    end
    drive_data();
    cnt    = 0;
    done   = 1'b0;
    arb_en = 1'b1;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (c > 0) step();
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (seq[i] < 10) && ($urandom_range(0, 3) != 0);
        req_last[i]  = (seq[i] % 3 == 2) || (seq[i] == 9);
      end
      rd        = ($urandom_range(0, 1) == 1);
      fifo_full = (cnt == 7);
      if (c == 0) #1;
      else @(negedge clk);
      if (fifo_wr_en) begin
        checks++;
        if (fifo_full) begin
          errors++;
          $display("FAIL stream_full_write c=%0d wr_en=1 while full", c);
        end
        checks++;
        if (fifo_din !== DW'(int'(fifo_src) * 256 + exp_seq[fifo_src])) begin
          errors++;
          $display("FAIL stream_order c=%0d src=%0d got din=%h exp %h", c, fifo_src, fifo_din,
                   DW'(int'(fifo_src) * 256 + exp_seq[fifo_src]));
        end
        exp_seq[fifo_src]++;
      end
      cnt = cnt + (fifo_wr_en ? 1 : 0) - ((rd && cnt > 0) ? 1 : 0);
      done = 1'b1;
      for (int i = 0; i < NREQ; i++) if (exp_seq[i] < 10) done = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (exp_seq[i] != 10) begin
        errors++;
        $display("FAIL stream_count req=%0d got %0d beats exp 10", i, exp_seq[i]);
      end
    end
    req_valid = '0;
    fifo_full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_async_reset();
    test_arb_en();
    test_fifo_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
